// File: rtl/text_vram_scheduler.sv
// text_vram_scheduler
// Owns the single-port text VRAM (600 words, four characters per word) and
// shares it between the display prefetch engine and the CPU bus. The display
// always wins its fetch slot. The fetched word is double-buffered so that the
// character byte for the current pixel is ready with no added latency.
module text_vram_scheduler #(
  parameter int RD_LAT     = 2,
  parameter int FETCH_SLOT = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [9:0]  i_drawX,
  input  logic [9:0]  i_drawY,
  input  logic [31:0] i_paletteIn,
  input  logic        i_cpuReq,
  input  logic        i_cpuWe,
  input  logic [9:0]  i_cpuAddr,
  input  logic [3:0]  i_cpuBe,
  input  logic [31:0] i_cpuWdata,
  output logic        o_cpuAck,
  output logic [31:0] o_cpuRdata,
  output logic [9:0]  o_vramAddr,
  output logic        o_vramRd,
  output logic        o_vramWe,
  output logic [3:0]  o_vramBe,
  output logic [31:0] o_vramWdata,
  input  logic [31:0] i_vramRdata,
  output logic [7:0]  o_drawCode,
  output logic [31:0] o_drawSig
);

  localparam logic [9:0] VRAM_WORDS  = 10'd600;
  localparam logic [9:0] ACTIVE_ROWS = 10'd480;
  localparam logic [9:0] LAST_ROW    = 10'd524;
  localparam logic [9:0] LAST_COL    = 10'd799;

  logic [4:0]  w_group;
  logic [4:0]  w_phase;
  logic [9:0]  w_nextY;
  logic [9:0]  w_rowBase;
  logic [9:0]  w_nextRowBase;
  logic [9:0]  w_fetchAddr;
  logic        w_fetchWanted;
  logic        w_fetch;
  logic        w_cpuIssue;
  logic        w_cpuInRange;
  logic        w_cpuStrobe;
  logic        w_retValid;
  logic        w_retCpu;
  logic        w_retZero;

  logic [31:0] r_curWord;
  logic [31:0] r_preWord;
  logic [31:0] r_cpuRdata;
  logic [31:0] r_drawSig;
  logic [31:0] r_vramWdata;
  logic [9:0]  r_vramAddr;
  logic [3:0]  r_vramBe;
  logic        r_cpuAck;
  logic        r_busy;
  logic [RD_LAT-1:0] r_tagValid;
  logic [RD_LAT-1:0] r_tagCpu;
  logic [RD_LAT-1:0] r_tagZero;

  assign w_group       = i_drawX[9:5];
  assign w_phase       = i_drawX[4:0];
  assign w_nextY       = (i_drawY == LAST_ROW) ? 10'd0 : i_drawY + 10'd1;
  assign w_rowBase     = {4'd0, i_drawY[9:4]} * 10'd20;
  assign w_nextRowBase = {4'd0, w_nextY[9:4]} * 10'd20;

  // Pick the word the display needs next: the following group on this line,
  // or group 0 of the next line once the visible groups are done.
  always_comb begin
    w_fetchWanted = 1'b0;
    w_fetchAddr   = 10'd0;
    if (w_phase == 5'(FETCH_SLOT)) begin
      if (w_group < 5'd19) begin
        w_fetchWanted = (i_drawY < ACTIVE_ROWS);
        w_fetchAddr   = w_rowBase + {5'd0, w_group} + 10'd1;
      end else if (w_group == 5'd24) begin
        w_fetchWanted = (w_nextY < ACTIVE_ROWS);
        w_fetchAddr   = w_nextRowBase;
      end
    end
  end

  assign w_fetch      = w_fetchWanted && !i_reset;
  assign w_cpuIssue   = i_cpuReq && !w_fetch && !r_busy && !r_cpuAck && !i_reset;
  assign w_cpuInRange = (i_cpuAddr < VRAM_WORDS);
  assign w_cpuStrobe  = w_cpuIssue && w_cpuInRange;

  assign w_retValid = r_tagValid[RD_LAT-1];
  assign w_retCpu   = r_tagCpu[RD_LAT-1];
  assign w_retZero  = r_tagZero[RD_LAT-1];

  assign o_vramRd    = w_fetch || (w_cpuStrobe && !i_cpuWe);
  assign o_vramWe    = w_cpuStrobe && i_cpuWe;
  assign o_vramAddr  = w_fetch ? w_fetchAddr : (w_cpuStrobe ? i_cpuAddr : r_vramAddr);
  assign o_vramBe    = o_vramWe ? i_cpuBe : r_vramBe;
  assign o_vramWdata = o_vramWe ? i_cpuWdata : r_vramWdata;

  assign o_cpuAck   = r_cpuAck;
  assign o_cpuRdata = r_cpuRdata;
  assign o_drawSig  = r_drawSig;
  assign o_drawCode = r_curWord[{i_drawX[4:3], 3'b000} +: 8];

  // Remember the last command fields so the VRAM bus holds steady when idle
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_vramAddr  <= 10'd0;
      r_vramBe    <= 4'd0;
      r_vramWdata <= 32'd0;
    end else begin
      r_vramAddr  <= o_vramAddr;
      r_vramBe    <= o_vramBe;
      r_vramWdata <= o_vramWdata;
    end
  end

  // Track every read in flight so returning data reaches the right consumer;
  // out-of-range CPU reads ride along with no strobe and return zero
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_tagValid <= '0;
      r_tagCpu   <= '0;
      r_tagZero  <= '0;
    end else begin
      r_tagValid[0] <= w_fetch || (w_cpuIssue && !i_cpuWe);
      r_tagCpu[0]   <= w_cpuIssue && !i_cpuWe;
      r_tagZero[0]  <= !w_cpuInRange;
      for (int k = 1; k < RD_LAT; k++) begin
        r_tagValid[k] <= r_tagValid[k-1];
        r_tagCpu[k]   <= r_tagCpu[k-1];
        r_tagZero[k]  <= r_tagZero[k-1];
      end
    end
  end

  // CPU side: single outstanding op, one-cycle ack, read data captured on return
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cpuAck   <= 1'b0;
      r_busy     <= 1'b0;
      r_cpuRdata <= 32'd0;
    end else begin
      r_cpuAck <= (w_cpuIssue && i_cpuWe) || (w_retValid && w_retCpu);
      if (w_cpuIssue && !i_cpuWe) begin
        r_busy <= 1'b1;
      end else if (w_retValid && w_retCpu) begin
        r_busy <= 1'b0;
      end
      if (w_retValid && w_retCpu) begin
        r_cpuRdata <= w_retZero ? 32'd0 : i_vramRdata;
      end
    end
  end

  // Display side: fill the prefetch buffer, swap it in at the end of each group,
  // and latch the palette only at the very last pixel of the frame
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_preWord <= 32'd0;
      r_curWord <= 32'd0;
      r_drawSig <= 32'd0;
    end else begin
      if (w_retValid && !w_retCpu) begin
        r_preWord <= i_vramRdata;
      end
      if (w_phase == 5'd31) begin
        r_curWord <= r_preWord;
      end
      if (i_drawX == LAST_COL && i_drawY == LAST_ROW) begin
        r_drawSig <= i_paletteIn;
      end
    end
  end

endmodule

// File: tb/tb_text_vram_scheduler.sv
// tb_text_vram_scheduler
// Drives the raster counters and CPU port of text_vram_scheduler, models the
// VRAM with its read latency, and compares against a word-level picture of
// the screen memory and the CPU timing rules.
module tb_text_vram_scheduler;

  localparam int RD_LAT     = 2;
  localparam int FETCH_SLOT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  drawX;
  logic [9:0]  drawY;
  logic [31:0] paletteIn;
  logic        cpuReq;
  logic        cpuWe;
  logic [9:0]  cpuAddr;
  logic [3:0]  cpuBe;
  logic [31:0] cpuWdata;
  logic        cpuAck;
  logic [31:0] cpuRdata;
  logic [9:0]  vramAddr;
  logic        vramRd;
  logic        vramWe;
  logic [3:0]  vramBe;
  logic [31:0] vramWdata;
  logic [31:0] vramRdata;
  logic [7:0]  drawCode;
  logic [31:0] drawSig;

  int errors = 0;
  int checks = 0;

  logic [31:0] mem    [0:599];
  logic [31:0] refMem [0:599];
  logic [31:0] readPipe [RD_LAT];
  logic        loadReq = 1'b0;

  always #5 clk = ~clk;

  text_vram_scheduler #(.RD_LAT(RD_LAT), .FETCH_SLOT(FETCH_SLOT)) dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_drawX     (drawX),
    .i_drawY     (drawY),
    .i_paletteIn (paletteIn),
    .i_cpuReq    (cpuReq),
    .i_cpuWe     (cpuWe),
    .i_cpuAddr   (cpuAddr),
    .i_cpuBe     (cpuBe),
    .i_cpuWdata  (cpuWdata),
    .o_cpuAck    (cpuAck),
    .o_cpuRdata  (cpuRdata),
    .o_vramAddr  (vramAddr),
    .o_vramRd    (vramRd),
    .o_vramWe    (vramWe),
    .o_vramBe    (vramBe),
    .o_vramWdata (vramWdata),
    .i_vramRdata (vramRdata),
    .o_drawCode  (drawCode),
    .o_drawSig   (drawSig)
  );

  // VRAM model: byte-enabled writes, reads returned RD_LAT cycles after the strobe
  always @(posedge clk) begin
    logic [31:0] merged;
    if (loadReq) begin
      for (int i = 0; i < 600; i++) mem[i] <= refMem[i];
    end else if (vramWe && vramAddr < 10'd600) begin
      merged = mem[vramAddr];
      for (int b = 0; b < 4; b++) begin
        if (vramBe[b]) merged[8*b +: 8] = vramWdata[8*b +: 8];
      end
      mem[vramAddr] <= merged;
    end
    readPipe[0] <= (vramRd && vramAddr < 10'd600) ? mem[vramAddr] : 32'hDEADBEEF;
    for (int k = 1; k < RD_LAT; k++) readPipe[k] <= readPipe[k-1];
  end
  assign vramRdata = readPipe[RD_LAT-1];

  // Count one comparison and report it if the observed value is wrong
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s @%0t: got 0x%08h expected 0x%08h", tag, $time, got, exp);
    end
  endtask

  // Advance one pixel clock: wait for the edge, then move the raster position
  task automatic applyStimulus();
    @(posedge clk);
    #1;
    if (drawX == 10'd799) begin
      drawX = 10'd0;
      drawY = (drawY == 10'd524) ? 10'd0 : drawY + 10'd1;
    end else begin
      drawX = drawX + 10'd1;
    end
  endtask

  // Screen rules: whether a display fetch happens at (x,y) and which word it reads
  function automatic bit fetchAt(input int x, input int y, output int addr);
    int g;
    int ny;
    addr = 0;
    if (x % 32 != FETCH_SLOT) return 1'b0;
    g = x / 32;
    if (g < 19) begin
      if (y >= 480) return 1'b0;
      addr = (y / 16) * 20 + g + 1;
      return 1'b1;
    end
    if (g == 24) begin
      ny = (y == 524) ? 0 : y + 1;
      if (ny >= 480) return 1'b0;
      addr = (ny / 16) * 20;
      return 1'b1;
    end
    return 1'b0;
  endfunction

  // Character byte that belongs on screen at (x,y)
  function automatic logic [7:0] pixelCode(input int x, input int y);
    logic [31:0] w;
    w = refMem[(y / 16) * 20 + x / 32];
    return w[8 * ((x / 8) % 4) +: 8];
  endfunction

  // Start at column 768 of startY and check every visible pixel of the next lines
  task automatic scanLines(input int startY, input int lines, input bit spot);
    drawX = 10'd768;
    drawY = 10'(startY);
    repeat (32 + lines * 800) begin
      #1;
      if (drawY < 10'd480 && drawX < 10'd640) begin
        checkOutput($sformatf("code y%0d x%0d", drawY, drawX), 32'(drawCode),
                    32'(pixelCode(int'(drawX), int'(drawY))));
        if (spot && drawY == 10'd0 && (drawX == 10'd0 || drawX == 10'd7))
          checkOutput("code x0..7", 32'(drawCode), 32'h41);
        if (spot && drawY == 10'd0 && (drawX == 10'd8 || drawX == 10'd15))
          checkOutput("code x8..15", 32'(drawCode), 32'h42);
        if (spot && drawY == 10'd0 && (drawX == 10'd32 || drawX == 10'd39))
          checkOutput("code x32..39", 32'(drawCode), 32'h45);
      end
      applyStimulus();
    end
  endtask

  // One CPU transaction raised in the current cycle; checks issue, ack timing and data
  task automatic cpuOp(input logic we, input logic [9:0] addr, input logic [3:0] be,
                       input logic [31:0] data, input string tag);
    int fa;
    int issueAt;
    int expLat;
    int lat;
    bit fetchNow;
    bit seenAck;
    logic [31:0] expData;
    cpuReq   = 1'b1;
    cpuWe    = we;
    cpuAddr  = addr;
    cpuBe    = be;
    cpuWdata = data;
    fetchNow = fetchAt(int'(drawX), int'(drawY), fa);
    issueAt  = fetchNow ? 1 : 0;
    expLat   = issueAt + (we ? 1 : RD_LAT + 1);
    seenAck  = 1'b0;
    lat      = -1;
    for (int c = 0; c < 20 && !seenAck; c++) begin
      #1;
      if (c == 0 && fetchNow) begin
        checkOutput({tag, " display first"}, {30'd0, vramWe, vramRd}, 32'd1);
        checkOutput({tag, " display addr"}, 32'(vramAddr), 32'(fa));
      end
      if (c == issueAt) begin
        if (addr < 10'd600) begin
          checkOutput({tag, " strobe"}, {30'd0, vramWe, vramRd}, we ? 32'd2 : 32'd1);
          checkOutput({tag, " addr"}, 32'(vramAddr), 32'(addr));
          if (we) begin
            checkOutput({tag, " be"}, 32'(vramBe), 32'(be));
            checkOutput({tag, " wdata"}, vramWdata, data);
          end
        end else begin
          checkOutput({tag, " no strobe"}, {30'd0, vramWe, vramRd}, 32'd0);
        end
      end
      if (cpuAck) begin
        seenAck = 1'b1;
        lat = c;
      end else begin
        applyStimulus();
      end
    end
    if (!seenAck) begin
      checkOutput({tag, " ack timeout"}, 32'd0, 32'd1);
    end else begin
      checkOutput({tag, " ack latency"}, 32'(lat), 32'(expLat));
      if (!we) begin
        expData = 32'd0;
        if (addr < 10'd600) expData = refMem[addr];
        checkOutput({tag, " rdata"}, cpuRdata, expData);
      end
    end
    if (we && addr < 10'd600) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) refMem[addr][8*b +: 8] = data[8*b +: 8];
      end
    end
    applyStimulus();
    cpuReq = 1'b0;
    #1;
    checkOutput({tag, " ack single"}, 32'(cpuAck), 32'd0);
    applyStimulus();
  endtask

  initial begin
    int bad;
    reset     = 1'b1;
    drawX     = 10'(FETCH_SLOT);
    drawY     = 10'd0;
    paletteIn = 32'h1111_2222;
    cpuReq    = 1'b1;
    cpuWe     = 1'b1;
    cpuAddr   = 10'd3;
    cpuBe     = 4'hF;
    cpuWdata  = 32'hCAFE_F00D;

    for (int i = 0; i < 600; i++) refMem[i] = $urandom;
    refMem[0]   = 32'h4443_4241;
    refMem[1]   = 32'h4847_4645;
    refMem[580] = 32'h1234_5678;
    loadReq = 1'b1;

    // Reset held with a pending request and the raster sitting on a fetch slot
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      loadReq = 1'b0;
      drawX   = 10'(FETCH_SLOT);
      drawY   = 10'd0;
      #1;
      checkOutput("reset vram_rd", 32'(vramRd), 32'd0);
      checkOutput("reset vram_we", 32'(vramWe), 32'd0);
      checkOutput("reset cpu_ack", 32'(cpuAck), 32'd0);
      checkOutput("reset vram_addr", 32'(vramAddr), 32'd0);
      checkOutput("reset vram_be", 32'(vramBe), 32'd0);
      checkOutput("reset vram_wdata", vramWdata, 32'd0);
      checkOutput("reset cpu_rdata", cpuRdata, 32'd0);
      checkOutput("reset draw_code", 32'(drawCode), 32'd0);
      checkOutput("reset draw_sig", drawSig, 32'd0);
    end

    @(posedge clk);
    #1;
    reset     = 1'b0;
    cpuReq    = 1'b0;
    paletteIn = 32'hA5A5_0F0F;
    drawX     = 10'd768;
    drawY     = 10'd524;
    #1;
    checkOutput("sig before frame edge", drawSig, 32'd0);
    scanLines(524, 2, 1'b1);
    checkOutput("sig after frame edge", drawSig, 32'hA5A5_0F0F);

    // Palette change mid-frame must not show until the frame boundary
    paletteIn = 32'h5A5A_F0F0;
    repeat (50) applyStimulus();
    #1;
    checkOutput("sig mid-frame", drawSig, 32'hA5A5_0F0F);
    drawX = 10'd798;
    drawY = 10'd524;
    applyStimulus();
    #1;
    checkOutput("sig at 799/524", drawSig, 32'hA5A5_0F0F);
    applyStimulus();
    #1;
    checkOutput("sig new frame", drawSig, 32'h5A5A_F0F0);

    // Fetch address and suppression near the bottom of the screen
    applyStimulus();
    drawY = 10'd463;
    drawX = 10'(768 + FETCH_SLOT);
    #1;
    checkOutput("fetch y463 rd", 32'(vramRd), 32'd1);
    checkOutput("fetch y463 addr", 32'(vramAddr), 32'd580);
    applyStimulus();
    drawY = 10'd479;
    drawX = 10'(768 + FETCH_SLOT);
    #1;
    checkOutput("fetch y479 rd", 32'(vramRd), 32'd0);
    applyStimulus();
    drawY = 10'd524;
    drawX = 10'(768 + FETCH_SLOT);
    #1;
    checkOutput("fetch y524 rd", 32'(vramRd), 32'd1);
    checkOutput("fetch y524 addr", 32'(vramAddr), 32'd0);
    applyStimulus();
    drawY = 10'd10;
    drawX = 10'(608 + FETCH_SLOT);
    #1;
    checkOutput("fetch g19 rd", 32'(vramRd), 32'd0);

    // CPU write colliding with a display fetch slot
    applyStimulus();
    drawY = 10'd10;
    drawX = 10'(32 + FETCH_SLOT);
    cpuOp(1'b1, 10'd5, 4'h3, 32'hAABB_CCDD, "collide wr");

    // CPU read while a display fetch is still in flight
    drawY = 10'd10;
    drawX = 10'd0;
    while (drawX != 10'(FETCH_SLOT + 1)) applyStimulus();
    cpuOp(1'b0, 10'd580, 4'h0, 32'd0, "rd 580");
    while (drawX != 10'd32) applyStimulus();
    for (int x = 32; x < 64; x++) begin
      #1;
      checkOutput($sformatf("prefetch kept x%0d", x), 32'(drawCode), 32'(pixelCode(x, 10)));
      applyStimulus();
    end

    // Out-of-range accesses: no strobe, normal ack timing, reads return zero
    cpuOp(1'b0, 10'd700, 4'h0, 32'd0, "rd 700");
    cpuOp(1'b1, 10'd700, 4'hF, 32'h0BAD_0BAD, "wr 700");

    // Randomized CPU traffic across the end of frame and the top rows
    drawY = 10'd523;
    drawX = 10'd0;
    for (int n = 0; n < 300; n++) begin
      logic        we;
      logic [9:0]  addr;
      we   = 1'($urandom_range(0, 1));
      addr = ($urandom_range(0, 99) < 85) ? 10'($urandom_range(0, 599))
                                          : 10'($urandom_range(600, 1023));
      cpuOp(we, addr, 4'($urandom_range(0, 15)), $urandom, $sformatf("op%0d", n));
      repeat ($urandom_range(0, 2)) applyStimulus();
    end

    // Memory image must match every accepted write
    bad = 0;
    for (int i = 0; i < 600; i++) if (mem[i] !== refMem[i]) bad++;
    checkOutput("vram words differing", 32'(bad), 32'd0);

    // Screen contents after the traffic, including a text-row boundary
    scanLines(524, 2, 1'b0);
    scanLines(14, 2, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
